// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the pipeline trace buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    ModeImm  = 2'd0,
    ModePc   = 2'd1,
    ModeNth  = 2'd2,
    ModeRsvd = 2'd3
  } trace_mode_e;

  function automatic int unsigned ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, synchronous one-cycle read.
module trace_ram #(
  parameter int unsigned DATA_W = 169,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array is never reset so it can map onto block RAM; only the output register is.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Armable, triggerable circular history of one pipeline stage word, drained oldest-first.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 169,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     arm_i,
  input  logic [1:0]               mode_i,
  input  logic [PC_W-1:0]          trig_pc_i,
  input  logic [CNT_W-1:0]         trig_count_i,
  input  logic [$clog2(DEPTH):0]   post_count_i,
  input  logic                     cap_valid_i,
  input  logic [PC_W-1:0]          cap_pc_i,
  input  logic [DATA_W-1:0]        cap_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     rd_empty_o,
  output logic [1:0]               state_o,
  output logic                     wrapped_o,
  output logic [CNT_W-1:0]         cap_total_o
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  trace_state_e       state_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    unread_q, post_left_q;
  logic               wrapped_q, rd_valid_q;
  logic [CNT_W-1:0]   cap_total_q;

  logic               capturing, trig_hit, rd_fire, wrapped_nxt;
  logic [PtrW-1:0]    wr_ptr_nxt;
  logic [CntW-1:0]    post_clamped;
  logic [CNT_W:0]     trig_n, cap_next;
  logic [CNT_W-1:0]   cap_total_sat;
  trace_mode_e        mode;

  always_comb begin
    mode      = trace_mode_e'(mode_i);
    capturing = (state_q == StArmed || state_q == StPost) && cap_valid_i && !arm_i;
    rd_fire   = (state_q == StDone) && rd_en_i && (unread_q != '0) && !arm_i;

    post_clamped = (post_count_i > CntW'(DEPTH - 1)) ? CntW'(DEPTH - 1) : post_count_i;

    // One bit wider than cap_total so a saturated counter can never match.
    trig_n   = (trig_count_i == '0) ? (CNT_W + 1)'(1) : {1'b0, trig_count_i};
    cap_next = {1'b0, cap_total_q} + (CNT_W + 1)'(1);

    unique case (mode)
      ModePc:  trig_hit = (cap_pc_i == trig_pc_i);
      ModeNth: trig_hit = (cap_next == trig_n);
      default: trig_hit = 1'b1;
    endcase

    wr_ptr_nxt    = wr_ptr_q + PtrW'(1);
    wrapped_nxt   = wrapped_q | (wr_ptr_q == PtrW'(DEPTH - 1));
    cap_total_sat = (cap_total_q == '1) ? cap_total_q : cap_total_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      unread_q    <= '0;
      post_left_q <= '0;
      wrapped_q   <= 1'b0;
      cap_total_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (arm_i) begin
        state_q     <= StArmed;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        unread_q    <= '0;
        post_left_q <= '0;
        wrapped_q   <= 1'b0;
        cap_total_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StArmed, StPost: begin
            if (capturing) begin
              wr_ptr_q    <= wr_ptr_nxt;
              wrapped_q   <= wrapped_nxt;
              cap_total_q <= cap_total_sat;
              if ((state_q == StArmed && trig_hit && post_clamped == '0) ||
                  (state_q == StPost && post_left_q == CntW'(1))) begin
                // Oldest entry sits at the write pointer once the ring has wrapped.
                state_q  <= StDone;
                rd_ptr_q <= wrapped_nxt ? wr_ptr_nxt : '0;
                unread_q <= wrapped_nxt ? CntW'(DEPTH) : {1'b0, wr_ptr_nxt};
              end else if (state_q == StArmed && trig_hit) begin
                state_q     <= StPost;
                post_left_q <= post_clamped;
              end else if (state_q == StPost) begin
                post_left_q <= post_left_q - CntW'(1);
              end
            end
          end
          StDone: begin
            if (rd_fire) begin
              rd_ptr_q <= rd_ptr_q + PtrW'(1);
              unread_q <= unread_q - CntW'(1);
            end
          end
        endcase
      end
    end
  end

  trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PtrW)
  ) u_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (capturing),
    .waddr_i (wr_ptr_q),
    .wdata_i (cap_data_i),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_o)
  );

  assign rd_valid_o  = rd_valid_q;
  assign rd_empty_o  = (state_q != StDone) || (unread_q == '0);
  assign state_o     = state_q;
  assign wrapped_o   = wrapped_q;
  assign cap_total_o = cap_total_q;

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Parametrised on-chip trace capture for the 5-stage pipeline; replaces fixed-length simulate-and-inspect with an armable, triggerable circular history of any stage's flat output word.
- Sits beside the core, fed from one stage bus (typically WB, 169 bits) plus that stage's PC.
- Holds pre-trigger history, freezes after a programmable post-trigger count, then drains oldest-first through a read port.

Parameters:
- DATA_W, 169, width of captured stage word.
- PC_W, 32, width of PC compared for the trigger.
- DEPTH, 16, entries; power of two, >= 4.
- CNT_W, 16, width of trig_count and of the capture counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- arm  in  1  one-cycle pulse; clear and start capture.
- mode  in  2  0=immediate, 1=PC match, 2=Nth capture, 3=reserved (treated as 0).
- trig_pc  in  PC_W  PC match value (mode 1).
- trig_count  in  CNT_W  N for mode 2, 1-based; 0 treated as 1.
- post_count  in  $clog2(DEPTH)+1  entries stored after the trigger entry; values >DEPTH-1 clamp to DEPTH-1.
- cap_valid  in  1  stage word valid this cycle.
- cap_pc  in  PC_W  PC of the captured word.
- cap_data  in  DATA_W  flat stage word.
- rd_en  in  1  pop oldest entry (DONE only).
- rd_data  out  DATA_W  popped entry.
- rd_valid  out  1  rd_data valid; high one cycle after an accepted rd_en.
- rd_empty  out  1  no unread entries.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- wrapped  out  1  buffer overwrote its oldest entry at least once since arm.
- cap_total  out  CNT_W  valid captures since arm, saturating.

Behaviour:
- Reset: state=IDLE, wr_ptr=0, rd_ptr=0, stored count=0, wrapped=0, cap_total=0, rd_valid=0, rd_empty=1, rd_data=0. RAM contents are not cleared.
- IDLE: cap_valid ignored. arm -> ARMED with pointers, counts, wrapped and cap_total cleared.
- ARMED: each cap_valid writes RAM[wr_ptr], wr_ptr++ mod DEPTH, cap_total++.
  - Writing at wr_ptr=DEPTH-1 sets wrapped.
  - Trigger is evaluated on the same cycle's capture:
    - mode 0: first capture.
    - mode 1: cap_pc==trig_pc.
    - mode 2: cap_total+1==max(trig_count,1).
  - The triggering entry is stored. Next state is DONE if clamped post_count==0, else POST with post_left=post_count.
- POST: each cap_valid writes as in ARMED and decrements post_left. Reaching 0 -> DONE. Trigger is not re-evaluated.
- DONE: writes stop.
  - On entry: rd_ptr = wrapped ? wr_ptr : 0; unread = wrapped ? DEPTH : wr_ptr.
  - rd_en with unread>0: RAM read at rd_ptr, rd_ptr++, unread--, rd_data/rd_valid valid next cycle (1-cycle sync read latency).
  - rd_en with unread==0 is ignored; rd_valid stays 0.
- rd_en outside DONE is ignored.
- rd_empty = (state!=DONE) || unread==0.
- arm in any state restarts into ARMED, clearing as from IDLE. arm has priority over a same-cycle capture; that capture is dropped.
- A reset mid-capture or mid-readout returns to the reset values on the next edge.
- cap_total saturates at 2^CNT_W-1. The mode 2 compare uses the unsaturated relation, so there is no trigger past saturation.
- Clamping post_count to DEPTH-1 guarantees the trigger entry is never overwritten.

Decomposition:
- Package trace_pkg holds:
  - trace_state_e (IDLE/ARMED/POST/DONE)
  - trace_mode_e
  - localparam helpers for pointer width.
- One sub-module, trace_ram: simple dual-port DEPTH x DATA_W, one write port, synchronous one-cycle read.
- The FSM, pointers and counters live in pipe_trace_buffer.

Test Plan (DEPTH=8, DATA_W=169, data = index):
- Reset, then arm mode 0, post_count=3, 10 continuous captures (data 1..10) -> DONE after 4th capture; rd_en x4 returns 1,2,3,4 then rd_empty=1, wrapped=0.
- Mode 1, trig_pc=0x40, PCs 0x00..0x4C step 4, data 1..20, post_count=2 -> trigger on data 17, DONE after data 19; wrapped=1; reads return 12..19 (8 entries).
- Mode 2, trig_count=5, post_count=0, gaps in cap_valid -> DONE on the 5th valid capture; reads return 1..5; cap_total=5.
- post_count=15 with DEPTH=8 -> clamped to 7; trigger entry is the oldest read after a wrap.
- arm pulsed while in POST, with a same-cycle capture -> that capture is dropped; state=ARMED, cap_total=0, wrapped=0.
- Reset asserted mid-readout after 2 of 8 reads -> next cycle state=IDLE, rd_valid=0, rd_empty=1; rd_en in IDLE gives no rd_valid.
